mem_req_arbiter: RTL



---
 rtl/mem_req_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// Two-to-one arbiter sharing one sram-like memory port between instruction fetch and data access.
// Accepted transfers are tagged in an in-order FIFO so each memory response returns to its issuer.
module mem_req_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        err_unexp_rsp
);

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_t;

    localparam int unsigned    PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(MAX_OUTSTANDING);

    logic             lock_valid;
    src_t             lock_src;
    src_t             last_src;
    src_t             tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic fifo_full;
    logic fifo_empty;
    logic grant_valid;
    src_t grant_src;
    logic accept;
    logic pop;
    src_t head_src;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign head_src   = tag_mem[rd_ptr];

    // A held lock outranks the full check: the pending address phase was granted before the FIFO filled.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_INST;
        if (lock_valid) begin
            grant_valid = 1'b1;
            grant_src   = lock_src;
        end else if (fifo_full) begin
            grant_valid = 1'b0;
        end else if (inst_req && data_req) begin
            grant_valid = 1'b1;
            grant_src   = (last_src == SRC_DATA) ? SRC_INST : SRC_DATA;
        end else if (data_req) begin
            grant_valid = 1'b1;
            grant_src   = SRC_DATA;
        end else if (inst_req) begin
            grant_valid = 1'b1;
            grant_src   = SRC_INST;
        end
    end

    always_comb begin
        mem_req   = grant_valid;
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_valid) begin
            if (grant_src == SRC_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_wstrb = inst_wstrb;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
    end

    assign accept       = grant_valid & mem_addr_ok;
    assign pop          = mem_data_ok & ~fifo_empty;

    assign inst_addr_ok = accept & (grant_src == SRC_INST);
    assign data_addr_ok = accept & (grant_src == SRC_DATA);
    assign inst_data_ok = pop & (head_src == SRC_INST);
    assign data_data_ok = pop & (head_src == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_valid    <= 1'b0;
            lock_src      <= SRC_INST;
            last_src      <= SRC_INST;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            if (accept) begin
                lock_valid <= 1'b0;
                last_src   <= grant_src;
                wr_ptr     <= wr_ptr + 1'b1;
            end else if (grant_valid) begin
                lock_valid <= 1'b1;
                lock_src   <= grant_src;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (!accept && pop) begin
                count <= count - 1'b1;
            end
            if (mem_data_ok && fifo_empty) begin
                err_unexp_rsp <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= grant_src;
        end
    end

endmodule
